// File: rtl/snitch_icache_pkg.sv
// Shared types for the read-only cache AR router: route encoding and flush FSM states.
package snitch_icache_pkg;

   typedef enum logic {
      Bypass = 1'b0,
      Cache  = 1'b1
   } route_e;

   typedef enum logic [1:0] {
      Idle  = 2'd0,
      Drain = 2'd1,
      Flush = 2'd2,
      Done  = 2'd3
   } ro_flush_state_e;

   localparam logic [1:0] AxiBurstWrap = 2'b10;

endpackage

// File: rtl/snitch_ro_cache_ar_router_if.sv
// AR request streams, cache R-last pulses, route selects and both flush handshakes.
interface snitch_ro_cache_ar_router_if #(
   parameter int unsigned NrPorts      = 2,
   parameter int unsigned AxiAddrWidth = 48
);

   logic [NrPorts-1:0]                   ar_valid_i;
   logic [NrPorts-1:0]                   ar_ready_i;
   logic [NrPorts-1:0]                   ar_lock_i;
   logic [NrPorts-1:0][AxiAddrWidth-1:0] ar_addr_i;
   logic [NrPorts-1:0][1:0]              ar_burst_i;
   logic [NrPorts-1:0][7:0]              ar_len_i;
   logic [NrPorts-1:0][2:0]              ar_size_i;
   logic [NrPorts-1:0]                   r_last_cache_i;
   logic [NrPorts-1:0]                   ar_select_o;
   logic                                 flush_valid_i;
   logic                                 flush_ready_o;
   logic                                 flush_valid_o;
   logic                                 flush_ready_i;

   modport slave (
      input  ar_valid_i, ar_ready_i, ar_lock_i, ar_addr_i, ar_burst_i, ar_len_i, ar_size_i,
      input  r_last_cache_i, flush_valid_i, flush_ready_i,
      output ar_select_o, flush_ready_o, flush_valid_o
   );

   modport master (
      output ar_valid_i, ar_ready_i, ar_lock_i, ar_addr_i, ar_burst_i, ar_len_i, ar_size_i,
      output r_last_cache_i, flush_valid_i, flush_ready_i,
      input  ar_select_o, flush_ready_o, flush_valid_o
   );

endinterface

// File: rtl/snitch_ro_cache_port_sel.sv
// Per-port route decision: address-rule decode, select held while the AR waits,
// and the outstanding cache-read counter.
module snitch_ro_cache_port_sel
   import snitch_icache_pkg::*;
#(
   parameter int unsigned NrAddrRules  = 1,
   parameter int unsigned AxiAddrWidth = 48,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned MaxTrans     = 4
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     i_enable,
   input  logic                                     i_flush_idle,
   input  logic [NrAddrRules-1:0]                   i_rule_en,
   input  logic [NrAddrRules-1:0][AxiAddrWidth-1:0] i_start_addr,
   input  logic [NrAddrRules-1:0][AxiAddrWidth-1:0] i_end_addr,
   input  logic                                     i_ar_valid,
   input  logic                                     i_ar_ready,
   input  logic                                     i_ar_lock,
   input  logic [AxiAddrWidth-1:0]                  i_ar_addr,
   input  logic [1:0]                               i_ar_burst,
   input  logic [7:0]                               i_ar_len,
   input  logic [2:0]                               i_ar_size,
   input  logic                                     i_r_last_cache,
   output route_e                                   o_ar_select,
   output logic                                     o_drained
);

   localparam int unsigned   CntW     = $clog2(MaxTrans + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);
   localparam logic [2:0]    FullSize = 3'($clog2(AxiDataWidth / 8));

   logic            r_waiting;
   route_e          r_select;
   logic [CntW-1:0] r_cnt;

   logic            w_hit;
   logic            w_cacheable;
   route_e          w_select;
   logic            w_inc;
   logic [CntW-1:0] w_cnt_d;

   // NOTE: w_hit gets its default before the loop, so no path leaves it unassigned (no latch).
   always_comb begin
      w_hit = 1'b0;
      for (int unsigned i = 0; i < NrAddrRules; i++) begin
         if (i_rule_en[i] && (i_ar_addr >= i_start_addr[i]) && (i_ar_addr < i_end_addr[i])) begin
            w_hit = 1'b1;
         end
      end
   end

   assign w_cacheable = i_enable && w_hit && !i_ar_lock && (i_ar_burst != AxiBurstWrap) &&
                        ((i_ar_len == 8'd0) || (i_ar_size == FullSize)) &&
                        (r_cnt < MaxCnt) && i_flush_idle;

   // A stalled AR keeps the route it was first presented with until accepted.
   assign w_select = r_waiting ? r_select : (w_cacheable ? Cache : Bypass);
   assign w_inc    = i_ar_valid && i_ar_ready && (w_select == Cache);

   always_comb begin
      w_cnt_d = r_cnt;
      if (w_inc && !i_r_last_cache && (r_cnt != MaxCnt)) begin
         w_cnt_d = r_cnt + CntW'(1);
      end else if (!w_inc && i_r_last_cache && (r_cnt != '0)) begin
         w_cnt_d = r_cnt - CntW'(1);
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_waiting <= 1'b0;
         r_select  <= Bypass;
         r_cnt     <= '0;
      end else begin
         r_waiting <= i_ar_valid && !i_ar_ready;
         r_select  <= w_select;
         r_cnt     <= w_cnt_d;
      end
   end

   // Drained looks at the post-update count so a final R-last releases the flush next cycle.
   assign o_ar_select = w_select;
   assign o_drained   = (w_cnt_d == '0) && !(r_waiting && (r_select == Cache));

endmodule

// File: rtl/snitch_ro_cache_ar_router.sv
// Routes each AR stream to the read-only cache or bypass and sequences cache flushes.
// Optional per-port handshake counters are enabled with `define SNITCH_RO_CACHE_PERF_EN.
module snitch_ro_cache_ar_router
   import snitch_icache_pkg::*;
#(
   parameter int unsigned NrPorts      = 2,
   parameter int unsigned NrAddrRules  = 1,
   parameter int unsigned AxiAddrWidth = 48,
   parameter int unsigned AxiDataWidth = 64,
   parameter int unsigned MaxTrans     = 4
) (
   input  logic                                     clk_i,
   input  logic                                     rst_ni,
   input  logic                                     enable_i,
   input  logic [NrAddrRules-1:0]                   rule_en_i,
   input  logic [NrAddrRules-1:0][AxiAddrWidth-1:0] start_addr_i,
   input  logic [NrAddrRules-1:0][AxiAddrWidth-1:0] end_addr_i,
   snitch_ro_cache_ar_router_if.slave               bus,
   output logic [NrPorts-1:0][31:0]                 cache_cnt_o,
   output logic [NrPorts-1:0][31:0]                 bypass_cnt_o
);

   ro_flush_state_e    r_state;
   ro_flush_state_e    w_state_d;
   logic               w_flush_idle;
   logic               w_flush_valid;
   logic               w_flush_ready;
   logic [NrPorts-1:0] w_drained;
   route_e             w_sel [NrPorts];

   assign w_flush_idle = (r_state == Idle);

   for (genvar p = 0; p < NrPorts; p++) begin : g_port
      snitch_ro_cache_port_sel #(
         .NrAddrRules  (NrAddrRules),
         .AxiAddrWidth (AxiAddrWidth),
         .AxiDataWidth (AxiDataWidth),
         .MaxTrans     (MaxTrans)
      ) u_port_sel (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .i_enable       (enable_i),
         .i_flush_idle   (w_flush_idle),
         .i_rule_en      (rule_en_i),
         .i_start_addr   (start_addr_i),
         .i_end_addr     (end_addr_i),
         .i_ar_valid     (bus.ar_valid_i[p]),
         .i_ar_ready     (bus.ar_ready_i[p]),
         .i_ar_lock      (bus.ar_lock_i[p]),
         .i_ar_addr      (bus.ar_addr_i[p]),
         .i_ar_burst     (bus.ar_burst_i[p]),
         .i_ar_len       (bus.ar_len_i[p]),
         .i_ar_size      (bus.ar_size_i[p]),
         .i_r_last_cache (bus.r_last_cache_i[p]),
         .o_ar_select    (w_sel[p]),
         .o_drained      (w_drained[p])
      );
      assign bus.ar_select_o[p] = (w_sel[p] == Cache);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_state <= Idle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_flush_valid = 1'b0;
      w_flush_ready = 1'b0;
      case (r_state)
         Idle:  if (bus.flush_valid_i) w_state_d = Drain;
         Drain: if (&w_drained) w_state_d = Flush;
         Flush: begin
            w_flush_valid = 1'b1;
            if (bus.flush_ready_i) w_state_d = Done;
         end
         Done: begin
            w_flush_ready = 1'b1;
            w_state_d     = Idle;
         end
         default: w_state_d = Idle;
      endcase
   end

   assign bus.flush_valid_o = w_flush_valid;
   assign bus.flush_ready_o = w_flush_ready;

`ifdef SNITCH_RO_CACHE_PERF_EN
   logic [NrPorts-1:0][31:0] r_cache_cnt;
   logic [NrPorts-1:0][31:0] r_bypass_cnt;

   // Free-running handshake counters; they wrap naturally at 2^32.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_cache_cnt  <= '0;
         r_bypass_cnt <= '0;
      end else begin
         for (int unsigned p = 0; p < NrPorts; p++) begin
            if (bus.ar_valid_i[p] && bus.ar_ready_i[p]) begin
               if (bus.ar_select_o[p]) r_cache_cnt[p]  <= r_cache_cnt[p] + 32'd1;
               else                    r_bypass_cnt[p] <= r_bypass_cnt[p] + 32'd1;
            end
         end
      end
   end

   assign cache_cnt_o  = r_cache_cnt;
   assign bypass_cnt_o = r_bypass_cnt;
`else
   assign cache_cnt_o  = '0;
   assign bypass_cnt_o = '0;
`endif

endmodule

// File: tb/tb_snitch_ro_cache_ar_router.sv
// Directed scoreboard bench for snitch_ro_cache_ar_router (2 ports, 2 rules, MaxTrans 2).
module tb_snitch_ro_cache_ar_router;

   localparam int unsigned NrPorts      = 2;
   localparam int unsigned NrAddrRules  = 2;
   localparam int unsigned AxiAddrWidth = 48;

   typedef enum int {K_SEL, K_FV, K_FR, K_CC, K_BC} kind_e;
   typedef struct {
      string       tag;
      kind_e       kind;
      int          port;
      logic [31:0] exp;
   } sb_t;

   logic clk = 1'b0;
   logic rst_ni;
   logic enable;
   logic [NrAddrRules-1:0]                   rule_en;
   logic [NrAddrRules-1:0][AxiAddrWidth-1:0] start_addr;
   logic [NrAddrRules-1:0][AxiAddrWidth-1:0] end_addr;
   logic [NrPorts-1:0][31:0]                 cache_cnt;
   logic [NrPorts-1:0][31:0]                 bypass_cnt;

   sb_t         sb_q [$];
   logic [31:0] m_cc [NrPorts];
   logic [31:0] m_bc [NrPorts];
   int          n_vec = 0;
   int          n_err = 0;

   snitch_ro_cache_ar_router_if #(.NrPorts(NrPorts), .AxiAddrWidth(AxiAddrWidth)) bus ();

   snitch_ro_cache_ar_router #(
      .NrPorts      (NrPorts),
      .NrAddrRules  (NrAddrRules),
      .AxiAddrWidth (AxiAddrWidth),
      .AxiDataWidth (64),
      .MaxTrans     (2)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .enable_i     (enable),
      .rule_en_i    (rule_en),
      .start_addr_i (start_addr),
      .end_addr_i   (end_addr),
      .bus          (bus),
      .cache_cnt_o  (cache_cnt),
      .bypass_cnt_o (bypass_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] perf_exp(input logic [31:0] model);
`ifdef SNITCH_RO_CACHE_PERF_EN
      return model;
`else
      return (model & 32'd0);
`endif
   endfunction

   function automatic logic [31:0] observe(input kind_e k, input int p);
      case (k)
         K_SEL:   return {31'b0, bus.ar_select_o[p]};
         K_FV:    return {31'b0, bus.flush_valid_o};
         K_FR:    return {31'b0, bus.flush_ready_o};
         K_CC:    return cache_cnt[p];
         K_BC:    return bypass_cnt[p];
         default: return 32'hdead_beef;
      endcase
   endfunction

   task automatic push(input string tag, input kind_e k, input int p, input logic [31:0] e);
      sb_t s;
      s.tag  = tag;
      s.kind = k;
      s.port = p;
      s.exp  = e;
      sb_q.push_back(s);
   endtask

   // One cycle: queue expectations, compare on the falling edge, advance the model.
   task automatic step(input string tag, input logic [1:0] e_sel, input logic e_fv, input logic e_fr);
      sb_t s;
      for (int p = 0; p < NrPorts; p++) begin
         push($sformatf("%s.sel%0d", tag, p), K_SEL, p, {31'b0, e_sel[p]});
         push($sformatf("%s.ccnt%0d", tag, p), K_CC, p, perf_exp(m_cc[p]));
         push($sformatf("%s.bcnt%0d", tag, p), K_BC, p, perf_exp(m_bc[p]));
      end
      push({tag, ".fvalid"}, K_FV, 0, {31'b0, e_fv});
      push({tag, ".fready"}, K_FR, 0, {31'b0, e_fr});
      @(negedge clk);
      while (sb_q.size() != 0) begin
         s = sb_q.pop_front();
         check(s.tag, observe(s.kind, s.port), s.exp);
      end
      for (int p = 0; p < NrPorts; p++) begin
         if (!rst_ni) begin
            m_cc[p] = 32'd0;
            m_bc[p] = 32'd0;
         end else if (bus.ar_valid_i[p] && bus.ar_ready_i[p]) begin
            if (e_sel[p]) m_cc[p] = m_cc[p] + 32'd1;
            else          m_bc[p] = m_bc[p] + 32'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ar(input int p, input logic v, input logic rdy, input logic [47:0] addr);
      bus.ar_valid_i[p] = v;
      bus.ar_ready_i[p] = rdy;
      bus.ar_addr_i[p]  = addr;
      bus.ar_len_i[p]   = 8'd3;
      bus.ar_size_i[p]  = 3'd3;
      bus.ar_burst_i[p] = 2'b01;
      bus.ar_lock_i[p]  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_ni        = 1'b0;
      enable        = 1'b1;
      rule_en       = 2'b11;
      start_addr[0] = 48'h1000;
      end_addr[0]   = 48'h2000;
      start_addr[1] = 48'h8000;
      end_addr[1]   = 48'h9000;
      bus.r_last_cache_i = '0;
      bus.flush_valid_i  = 1'b0;
      bus.flush_ready_i  = 1'b0;
      for (int p = 0; p < NrPorts; p++) begin
         ar(p, 1'b0, 1'b0, 48'h0);
         m_cc[p] = 32'd0;
         m_bc[p] = 32'd0;
      end
      @(posedge clk);
      #1;
      step("reset", 2'b00, 1'b0, 1'b0);
      rst_ni = 1'b1;

      // Address decode and qualifiers
      ar(0, 1'b0, 1'b0, 48'h1000);   step("dec_hit",   2'b01, 1'b0, 1'b0);
      rule_en = 2'b00;               step("rule_off",  2'b00, 1'b0, 1'b0);
      rule_en = 2'b11;
      bus.ar_addr_i[0] = 48'h1fff;   step("last_in",   2'b01, 1'b0, 1'b0);
      bus.ar_addr_i[0] = 48'h2000;   step("end_excl",  2'b00, 1'b0, 1'b0);
      bus.ar_addr_i[0] = 48'h0fff;   step("below",     2'b00, 1'b0, 1'b0);
      bus.ar_addr_i[0] = 48'h8000;   step("rule1",     2'b01, 1'b0, 1'b0);
      bus.ar_addr_i[0] = 48'h1000;
      bus.ar_lock_i[0] = 1'b1;
      ar(1, 1'b0, 1'b0, 48'h1800);   step("lock",      2'b10, 1'b0, 1'b0);
      bus.ar_lock_i[0]  = 1'b0;
      bus.ar_burst_i[0] = 2'b10;     step("wrap",      2'b10, 1'b0, 1'b0);
      bus.ar_burst_i[0] = 2'b01;
      bus.ar_size_i[0]  = 3'd2;      step("narrow_bst", 2'b10, 1'b0, 1'b0);
      bus.ar_len_i[0]   = 8'd0;      step("narrow_one", 2'b11, 1'b0, 1'b0);
      ar(0, 1'b0, 1'b0, 48'h1000);
      enable = 1'b0;                 step("disabled",  2'b00, 1'b0, 1'b0);
      enable = 1'b1;
      ar(1, 1'b0, 1'b0, 48'h0);

      // Select held while the AR is stalled
      ar(0, 1'b1, 1'b0, 48'h1000);   step("hold_c1",   2'b01, 1'b0, 1'b0);
      enable = 1'b0;                 step("hold_c2",   2'b01, 1'b0, 1'b0);
      bus.ar_addr_i[0] = 48'h5000;   step("hold_c3",   2'b01, 1'b0, 1'b0);
      bus.ar_ready_i[0] = 1'b1;      step("hold_acc",  2'b01, 1'b0, 1'b0);
      ar(0, 1'b0, 1'b0, 48'h1000);   step("after_acc", 2'b00, 1'b0, 1'b0);
      enable = 1'b1;

      // Outstanding limit (one already in flight)
      ar(0, 1'b1, 1'b1, 48'h1000);   step("mt_second", 2'b01, 1'b0, 1'b0);
                                     step("mt_full",   2'b00, 1'b0, 1'b0);
      ar(0, 1'b0, 1'b0, 48'h1000);
      bus.r_last_cache_i[0] = 1'b1;  step("mt_rlast",  2'b00, 1'b0, 1'b0);
      bus.r_last_cache_i[0] = 1'b0;  step("mt_free",   2'b01, 1'b0, 1'b0);

      // Simultaneous increment and decrement, then saturation and underflow
      ar(0, 1'b1, 1'b1, 48'h1000);
      bus.r_last_cache_i[0] = 1'b1;  step("sim_incdec", 2'b01, 1'b0, 1'b0);
      ar(0, 1'b0, 1'b0, 48'h1000);
      bus.r_last_cache_i[0] = 1'b0;  step("sim_cnt1",  2'b01, 1'b0, 1'b0);
      ar(0, 1'b1, 1'b1, 48'h1000);   step("sim_fill",  2'b01, 1'b0, 1'b0);
      ar(0, 1'b0, 1'b0, 48'h1000);   step("sim_full",  2'b00, 1'b0, 1'b0);
      bus.r_last_cache_i[0] = 1'b1;  step("drain1",    2'b00, 1'b0, 1'b0);
                                     step("drain2",    2'b01, 1'b0, 1'b0);
                                     step("underflow", 2'b01, 1'b0, 1'b0);
      bus.r_last_cache_i[0] = 1'b0;  step("no_wrap",   2'b01, 1'b0, 1'b0);

      // Flush with one read outstanding
      ar(0, 1'b1, 1'b1, 48'h1000);   step("fl_load",   2'b01, 1'b0, 1'b0);
      ar(0, 1'b0, 1'b0, 48'h1000);
      bus.flush_valid_i = 1'b1;      step("fl_req",    2'b01, 1'b0, 1'b0);
      ar(1, 1'b0, 1'b0, 48'h1800);   step("fl_drain",  2'b00, 1'b0, 1'b0);
      bus.r_last_cache_i[0] = 1'b1;  step("fl_rlast",  2'b00, 1'b0, 1'b0);
      bus.r_last_cache_i[0] = 1'b0;  step("fl_valid",  2'b00, 1'b1, 1'b0);
                                     step("fl_wait",   2'b00, 1'b1, 1'b0);
      bus.flush_ready_i = 1'b1;      step("fl_rdy",    2'b00, 1'b1, 1'b0);
      bus.flush_ready_i = 1'b0;
      bus.flush_valid_i = 1'b0;      step("fl_done",   2'b00, 1'b0, 1'b1);
                                     step("fl_idle",   2'b11, 1'b0, 1'b0);

      // Held cache select survives the drain, then reset abandons the flush
      ar(0, 1'b0, 1'b0, 48'h0);
      ar(1, 1'b1, 1'b0, 48'h1800);
      bus.flush_valid_i = 1'b1;      step("h_wait",    2'b10, 1'b0, 1'b0);
                                     step("h_drain1",  2'b10, 1'b0, 1'b0);
      bus.ar_addr_i[1] = 48'h0;      step("h_drain2",  2'b10, 1'b0, 1'b0);
      bus.ar_ready_i[1] = 1'b1;      step("h_acc",     2'b10, 1'b0, 1'b0);
      ar(1, 1'b0, 1'b0, 48'h0);
      bus.r_last_cache_i[1] = 1'b1;  step("h_rlast",   2'b00, 1'b0, 1'b0);
      bus.r_last_cache_i[1] = 1'b0;  step("h_flush",   2'b00, 1'b1, 1'b0);
      rst_ni = 1'b0;
      bus.flush_ready_i = 1'b1;
      bus.flush_valid_i = 1'b0;      step("rst_flush", 2'b00, 1'b1, 1'b0);
      rst_ni = 1'b1;
      bus.flush_ready_i = 1'b0;      step("rst_fv_lo", 2'b00, 1'b0, 1'b0);
      ar(0, 1'b0, 1'b0, 48'h1000);   step("rst_nodone", 2'b01, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
